// File: rtl/volume_control_if.sv
// Sample stream between the wave generator, the volume stage and the DAC path.
// Latency: none, this interface only bundles wires.
// Backpressure: none, the stream advances one sample per clock.
//   inwave  : offset-binary input sample (midpoint = silence)
//   control : requested volume level, 0 = mute .. 7 = unity
//   outwave : scaled offset-binary output sample
interface volume_control_if #(
  parameter int WIDTH = 14
);
  logic [WIDTH-1:0] inwave;
  logic [2:0]       control;
  logic [WIDTH-1:0] outwave;

  modport master (output inwave, output control, input outwave);
  modport slave  (input inwave, input control, output outwave);
endinterface

// File: rtl/volume_control.sv
// Volume stage: scales an offset-binary sample by 2^-(7-level), level 0 mutes.
// Latency: 1 cycle inwave->outwave; control->output 2 cycles, deferred to a zero crossing or timeout when gated.
// Backpressure: none, one sample accepted and produced every clock.
//   clk, rst_n : clock, asynchronous active-low reset
//   aud        : slave side of volume_control_if (inwave, control in; outwave out)
module volume_control #(
  parameter int WIDTH      = 14,
  parameter int ZC_TIMEOUT = 1024,
  parameter bit ZC_ENABLE  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  volume_control_if.slave  aud
);

  localparam int CW = (ZC_TIMEOUT > 2) ? $clog2(ZC_TIMEOUT) : 1;
  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]    ctrl_q;
  logic [2:0]    lvl;
  logic [2:0]    lvl_nxt;
  logic          pending;
  logic          pend_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          prev_sign;
  logic          zc;
  logic [2:0]    shamt;

  logic signed [WIDTH-1:0] c;
  logic signed [WIDTH-1:0] shifted;
  logic        [WIDTH-1:0] out_nxt;

  // Offset binary to two's complement is just an MSB flip.
  assign c  = {~aud.inwave[WIDTH-1], aud.inwave[WIDTH-2:0]};
  assign zc = c[WIDTH-1] != prev_sign;

  // Level selection. The level chosen here is applied to the sample being
  // processed this cycle, so an update lands exactly on the crossing sample.
  always_comb begin
    lvl_nxt  = lvl;
    pend_nxt = pending;
    cnt_nxt  = cnt;
    if (!ZC_ENABLE) begin
      lvl_nxt = ctrl_q;
    end else if (!pending) begin
      if (ctrl_q != lvl) begin
        pend_nxt = 1'b1;
        cnt_nxt  = '0;
      end
    end else if (ctrl_q == lvl) begin
      // Request withdrawn before it took effect.
      pend_nxt = 1'b0;
      cnt_nxt  = '0;
    end else if (zc || cnt == CW'(ZC_TIMEOUT - 1)) begin
      // ctrl_q is always the newest request, so a retarget while pending
      // needs no extra handling and the counter keeps running.
      lvl_nxt  = ctrl_q;
      pend_nxt = 1'b0;
      cnt_nxt  = '0;
    end else begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // Arithmetic shift floors toward -inf; magnitude only shrinks, so no
  // overflow is possible when converting back to offset binary.
  assign shamt   = 3'd7 - lvl_nxt;
  assign shifted = c >>> shamt;
  assign out_nxt = (lvl_nxt == 3'd0) ? MID : {~shifted[WIDTH-1], shifted[WIDTH-2:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= 3'd7;
      lvl         <= 3'd7;
      pending     <= 1'b0;
      cnt         <= '0;
      prev_sign   <= 1'b0;
      aud.outwave <= MID;
    end else begin
      ctrl_q      <= aud.control;
      lvl         <= lvl_nxt;
      pending     <= pend_nxt;
      cnt         <= cnt_nxt;
      prev_sign   <= c[WIDTH-1];
      aud.outwave <= out_nxt;
    end
  end

endmodule

// File: tb/tb_volume_control.sv
// Directed bench for volume_control: gated instance (default parameters)
// plus an ungated instance (ZC_ENABLE=0) sharing clock and reset.
// Inputs are driven and outputs sampled on the falling edge.
module tb_volume_control;

  localparam int T = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  volume_control_if #(.WIDTH(14)) vif ();
  volume_control_if #(.WIDTH(14)) vif0 ();

  volume_control #(.WIDTH(14), .ZC_TIMEOUT(T), .ZC_ENABLE(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .aud   (vif.slave)
  );

  volume_control #(.WIDTH(14), .ZC_TIMEOUT(T), .ZC_ENABLE(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .aud   (vif0.slave)
  );

  // Stimulus only: request a level and force a zero crossing so it takes effect.
  task automatic set_level(input logic [2:0] l);
    vif.control = l;
    vif.inwave  = 14'h2400;
    repeat (4) @(negedge clk);
    vif.inwave  = 14'h1C00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    vif.inwave   = 14'h3000;
    vif.control  = 3'd7;
    vif0.inwave  = 14'h2000;
    vif0.control = 3'd7;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h2000) begin
      failures++;
      $display("FAIL reset_out got=%h exp=2000", vif.outwave);
    end
    checks++;
    if (vif0.outwave !== 14'h2000) begin
      failures++;
      $display("FAIL reset_out_nozc got=%h exp=2000", vif0.outwave);
    end
    vif.inwave = 14'h2000;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unity;
    logic [13:0] w;
    int bad = 0;
    set_level(3'd7);
    for (int i = 0; i < 100; i++) begin
      w = 14'h2000 + 14'(8 * i);
      vif.inwave = w;
      @(negedge clk);
      checks++;
      if (vif.outwave !== w) begin
        failures++;
        if (bad < 5) $display("FAIL unity_ramp i=%0d got=%h exp=%h", i, vif.outwave, w);
        bad++;
      end
    end
  endtask

  task automatic test_shift;
    set_level(3'd6);
    vif.inwave = 14'h2100;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h2080) begin
      failures++;
      $display("FAIL shift_l6 got=%h exp=2080", vif.outwave);
    end
    set_level(3'd5);
    vif.inwave = 14'h1F00;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h1FC0) begin
      failures++;
      $display("FAIL shift_l5 got=%h exp=1fc0", vif.outwave);
    end
    vif.inwave = 14'h2000;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h2000) begin
      failures++;
      $display("FAIL silence_l5 got=%h exp=2000", vif.outwave);
    end
  endtask

  task automatic test_extremes;
    set_level(3'd1);
    vif.inwave = 14'h0000;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h1F80) begin
      failures++;
      $display("FAIL ext_min got=%h exp=1f80", vif.outwave);
    end
    vif.inwave = 14'h3FFF;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h207F) begin
      failures++;
      $display("FAIL ext_max got=%h exp=207f", vif.outwave);
    end
    vif.inwave = 14'h2000;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h2000) begin
      failures++;
      $display("FAIL silence_l1 got=%h exp=2000", vif.outwave);
    end
  endtask

  task automatic test_mute;
    logic [13:0] w;
    set_level(3'd0);
    for (int i = 0; i < 18; i++) begin
      if (i == 0)      w = 14'h0000;
      else if (i == 1) w = 14'h3FFF;
      else             w = 14'((i - 2) * 14'h0400 + 14'h0123);
      vif.inwave = w;
      @(negedge clk);
      checks++;
      if (vif.outwave !== 14'h2000) begin
        failures++;
        $display("FAIL mute in=%h got=%h exp=2000", w, vif.outwave);
      end
    end
  endtask

  task automatic test_zero_cross;
    set_level(3'd7);
    vif.inwave = 14'h2400;
    repeat (2) @(negedge clk);
    vif.control = 3'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (vif.outwave !== 14'h2400) begin
        failures++;
        $display("FAIL zc_hold cyc=%0d got=%h exp=2400", i, vif.outwave);
      end
    end
    vif.inwave = 14'h1C00;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h1E00) begin
      failures++;
      $display("FAIL zc_apply got=%h exp=1e00", vif.outwave);
    end
  endtask

  task automatic test_revert;
    set_level(3'd7);
    vif.inwave = 14'h2400;
    repeat (2) @(negedge clk);
    vif.control = 3'd5;
    repeat (3) @(negedge clk);
    vif.control = 3'd7;
    repeat (3) @(negedge clk);
    vif.inwave = 14'h1C00;
    @(negedge clk);
    checks++;
    if (vif.outwave !== 14'h1C00) begin
      failures++;
      $display("FAIL revert got=%h exp=1c00", vif.outwave);
    end
  endtask

  task automatic test_no_zc;
    vif0.inwave  = 14'h2400;
    vif0.control = 3'd6;
    @(negedge clk);
    checks++;
    if (vif0.outwave !== 14'h2400) begin
      failures++;
      $display("FAIL nozc_lat1 got=%h exp=2400", vif0.outwave);
    end
    @(negedge clk);
    checks++;
    if (vif0.outwave !== 14'h2200) begin
      failures++;
      $display("FAIL nozc_lat2 got=%h exp=2200", vif0.outwave);
    end
    vif0.control = 3'd7;
  endtask

  task automatic test_timeout;
    int k = 0;
    bit found = 1'b0;
    bit early = 1'b0;
    logic [13:0] first_bad = 14'h0;
    set_level(3'd7);
    vif.inwave = 14'h2400;
    repeat (2) @(negedge clk);
    vif.control = 3'd6;
    while (!found && k < T + 20) begin
      @(negedge clk);
      k++;
      if (vif.outwave === 14'h2200) found = 1'b1;
      else if (vif.outwave !== 14'h2400 && !early) begin
        early = 1'b1;
        first_bad = vif.outwave;
      end
    end
    checks++;
    if (early) begin
      failures++;
      $display("FAIL timeout_hold got=%h exp=2400", first_bad);
    end
    checks++;
    if (!found || k < T || k > T + 2) begin
      failures++;
      $display("FAIL timeout_apply found=%0d cycles=%0d exp=%0d..%0d", found, k, T, T + 2);
    end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    set_level(3'd7);
    vif.inwave = 14'h2400;
    repeat (2) @(negedge clk);
    vif.control = 3'd6;
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (vif.outwave !== 14'h2000) begin
      failures++;
      $display("FAIL reset_async got=%h exp=2000", vif.outwave);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Level is back at 7 and the old countdown is gone: no change for 600 cycles.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (vif.outwave !== 14'h2400) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_level bad_cycles=%0d got=%h exp=2400", bad, vif.outwave);
    end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_shift();
    test_extremes();
    test_mute();
    test_zero_cross();
    test_revert();
    test_no_zc();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
